lshift_8: RTL and testbench

//  - 8-bit logical left barrel shifter with a registered output.
//  - Shifts data left by 0..7 positions and fills vacated LSBs with 0; bits shifted out of the MSB are discarded.
//  - Serves as the left-shift leaf of the barrel-shifter datapath and feeds downstream registered logic.

---
 rtl/lshift_pkg.sv | 10 +
 rtl/lshift_stage.sv | 13 +
 rtl/lshift_8.sv | 59 +++++
 tb/tb_lshift_8.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/lshift_pkg.sv
// Shared widths and data types for the 8-bit left barrel shifter.
package lshift_pkg;

   localparam int LSHIFT_WIDTH = 8;
   localparam int LSHIFT_SELW  = 3;

   typedef logic [LSHIFT_WIDTH-1:0] lshift_data_t;
   typedef logic [LSHIFT_SELW-1:0]  lshift_sel_t;

endpackage

// File: rtl/lshift_stage.sv
// One barrel-shifter rank: conditionally shifts left by a fixed SHIFT, zero filling.
module lshift_stage #(
   parameter int WIDTH = 8,
   parameter int SHIFT = 1
) (
   input  logic             en,
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] y
);

   assign y = en ? {a[WIDTH-1-SHIFT:0], {SHIFT{1'b0}}} : a;

endmodule

// File: rtl/lshift_8.sv
// 8-bit logical left barrel shifter with registered output, 1-cycle latency.
// Optional registered result-is-zero flag when LSHIFT_8_ZERO_FLAG_EN is defined.
module lshift_8
   import lshift_pkg::*;
#(
   parameter int WIDTH = LSHIFT_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         data,
   input  logic [$clog2(WIDTH)-1:0] lsel,
   output logic [WIDTH-1:0]         out
`ifdef LSHIFT_8_ZERO_FLAG_EN
   ,
   output logic                     zero
`endif
);

   localparam int SELW = $clog2(WIDTH);

   // w_rank[0] is the operand; rank k+1 has optionally shifted by 2**k.
   logic [SELW:0][WIDTH-1:0] w_rank;
   logic [WIDTH-1:0]         r_out;

   assign w_rank[0] = data;

   genvar k;
   generate
      for (k = 0; k < SELW; k++) begin : g_rank
         lshift_stage #(
            .WIDTH (WIDTH),
            .SHIFT (1 << k)
         ) u_stage (
            .en (lsel[k]),
            .a  (w_rank[k]),
            .y  (w_rank[k+1])
         );
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_out <= '0;
      else     r_out <= w_rank[SELW];
   end

   assign out = r_out;

`ifdef LSHIFT_8_ZERO_FLAG_EN
   logic r_zero;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_zero <= 1'b0;
      else     r_zero <= (w_rank[SELW] == '0);
   end

   assign zero = r_zero;
`endif

endmodule

// File: tb/tb_lshift_8.sv
// Directed and random-vector bench for lshift_8 (covers LSHIFT_8_ZERO_FLAG_EN when defined).
module tb_lshift_8;

   logic       clk;
   logic       rst;
   logic [7:0] data;
   logic [2:0] lsel;
   logic [7:0] out;
`ifdef LSHIFT_8_ZERO_FLAG_EN
   logic       zero;
`endif

   int n_vec;
   int n_err;

   lshift_8 dut (
      .clk  (clk),
      .rst  (rst),
      .data (data),
      .lsel (lsel),
      .out  (out)
`ifdef LSHIFT_8_ZERO_FLAG_EN
      ,
      .zero (zero)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] lsh(input logic [7:0] d, input logic [2:0] s);
      logic [7:0] r;
      r = d << s;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; result checked just after the next one.
   task automatic step(input logic [7:0] d, input logic [2:0] s, input string tag);
      data = d;
      lsel = s;
      @(posedge clk);
      #1;
      chk(tag, out, lsh(d, s));
`ifdef LSHIFT_8_ZERO_FLAG_EN
      chk({tag, "_z"}, {7'd0, zero}, {7'd0, lsh(d, s) == 8'h00});
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] sweep_exp [8];
      logic [7:0] d;
      logic [2:0] s;
      n_vec = 0;
      n_err = 0;
      sweep_exp = '{8'hA5, 8'h4A, 8'h94, 8'h28, 8'h50, 8'hA0, 8'h40, 8'h80};

      // Reset applied at time 0, checked before the first clock edge.
      rst  = 1'b1;
      data = 8'hFF;
      lsel = 3'd3;
      #1;
      chk("rst_async", out, 8'h00);
`ifdef LSHIFT_8_ZERO_FLAG_EN
      chk("rst_async_z", {7'd0, zero}, 8'h00);
`endif
      @(posedge clk);
      #1;
      chk("rst_held", out, 8'h00);
      rst = 1'b0;

      // Sweep with hand-computed values.
      for (int i = 0; i < 8; i++) begin
         data = 8'hA5;
         lsel = 3'(i);
         @(posedge clk);
         #1;
         chk($sformatf("sweep%0d", i), out, sweep_exp[i]);
      end

      // Boundary shifts.
      data = 8'h01; lsel = 3'd7;
      @(posedge clk); #1;
      chk("edge_01_7", out, 8'h80);
      data = 8'h80; lsel = 3'd1;
      @(posedge clk); #1;
      chk("edge_80_1", out, 8'h00);
      data = 8'h3C; lsel = 3'd0;
      @(posedge clk); #1;
      chk("pass_3C_0", out, 8'h3C);

      // Latency: output must not move before the capturing edge.
      data = 8'hFF; lsel = 3'd2;
      #3;
      chk("no_early", out, 8'h3C);
      @(posedge clk); #1;
      chk("lat_FF_2", out, 8'hFC);

`ifdef LSHIFT_8_ZERO_FLAG_EN
      data = 8'hF0; lsel = 3'd4;
      @(posedge clk); #1;
      chk("zf_out_F0", out, 8'h00);
      chk("zf_z_F0", {7'd0, zero}, 8'h01);
      data = 8'h0F; lsel = 3'd4;
      @(posedge clk); #1;
      chk("zf_out_0F", out, 8'hF0);
      chk("zf_z_0F", {7'd0, zero}, 8'h00);
`endif

      // Back-to-back random vectors.
      for (int i = 0; i < 1000; i++) begin
         d = 8'($urandom);
         s = 3'($urandom_range(0, 7));
         step(d, s, "rand");
      end

      // Mid-stream reset pulse between edges.
      step(8'h5A, 3'd1, "pre_rst");
      data = 8'hC3;
      lsel = 3'd2;
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst", out, 8'h00);
`ifdef LSHIFT_8_ZERO_FLAG_EN
      chk("mid_rst_z", {7'd0, zero}, 8'h00);
`endif
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst", out, 8'h0C);
      step(8'h81, 3'd3, "post_rst2");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
